// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_rx_pkg;

  typedef logic [7:0] uart_byte_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side handshake from uart_rx to the command parser.
interface uart_rx_if;
  import uart_rx_pkg::*;

  uart_byte_t rx_data;
  logic       new_rx_data;
  logic       frame_err;
  logic       busy;

  modport master (output rx_data, output new_rx_data, output frame_err, output busy);
  modport slave  (input  rx_data, input  new_rx_data, input  frame_err, input  busy);
endinterface

// File: rtl/uart_rx_baud_tick.sv
// Reloadable bit-period down-counter; tick marks a sample point while enabled.
module uart_rx_baud_tick
  import uart_rx_pkg::*;
#(
  parameter int unsigned DIV = 434,
  parameter int unsigned W   = clog2(DIV)
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tick
);

  localparam logic [W-1:0] RELOAD = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = tick ? RELOAD : cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises the pin, samples mid-bit, checks start/stop framing.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned BAUD_DIV    = 434,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic      clk,
  input  logic      rstn,
  input  logic      rx,
  uart_rx_if.master bus
);

  localparam int unsigned DIV_W = clog2(BAUD_DIV);
  localparam logic [DIV_W-1:0] HALF_LOAD = DIV_W'(BAUD_DIV / 2 - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] START    = 3'd1;
  localparam logic [2:0] DATA     = 3'd2;
  localparam logic [2:0] STOP     = 3'd3;
  localparam logic [2:0] BRK_WAIT = 3'd4;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [2:0]             state_q, state_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  uart_byte_t             shift_q, shift_d;
  uart_byte_t             data_q, data_d;
  logic                   strobe_q, strobe_d;
  logic                   err_q, err_d;
  logic                   div_load;
  logic                   tick;

  // Reset to idle-high so a line held low out of reset looks like a start edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  uart_rx_baud_tick #(
    .DIV (BAUD_DIV),
    .W   (DIV_W)
  ) u_baud_tick (
    .clk      (clk),
    .rstn     (rstn),
    .en       (state_q != IDLE),
    .load     (div_load),
    .load_val (HALF_LOAD),
    .tick     (tick)
  );

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    strobe_d  = 1'b0;
    err_d     = 1'b0;
    div_load  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          div_load = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        if (tick) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            bit_idx_d = 3'd0;
            state_d   = DATA;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (rx_s) begin
            data_d   = shift_q;
            strobe_d = 1'b1;
            state_d  = IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = BRK_WAIT;
          end
        end
      end
      BRK_WAIT: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      bit_idx_q <= 3'd0;
      shift_q   <= '0;
      data_q    <= '0;
      strobe_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      strobe_q  <= strobe_d;
      err_q     <= err_d;
    end
  end

  assign bus.rx_data     = data_q;
  assign bus.new_rx_data = strobe_q;
  assign bus.frame_err   = err_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames against a byte/latency reference model.
module tb_uart_rx;

  localparam int unsigned BAUD = 8;
  localparam int unsigned SYNC = 2;
  localparam int unsigned LAT  = SYNC + 1 + BAUD / 2 + 9 * BAUD;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic rx   = 1'b1;

  uart_rx_if bus ();

  uart_rx #(
    .BAUD_DIV    (BAUD),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .rx   (rx),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned strobe_cyc[$];
  logic [7:0]  strobe_dat[$];
  int unsigned err_cyc[$];
  int unsigned overlap = 0;

  always @(posedge clk) begin
    #1;
    if (bus.new_rx_data === 1'b1) begin
      strobe_cyc.push_back(cyc);
      strobe_dat.push_back(bus.rx_data);
    end
    if (bus.frame_err === 1'b1) err_cyc.push_back(cyc);
    if (bus.new_rx_data === 1'b1 && bus.frame_err === 1'b1) overlap++;
  end

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_fail   = 0;
  logic [7:0]  last_good = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_queues();
    strobe_cyc.delete();
    strobe_dat.delete();
    err_cyc.delete();
  endtask

  // Start bit, 8 data bits LSB first, then the given stop level; line stays at stop level.
  task automatic send_frame(input logic [7:0] d, input logic stop, output int unsigned p);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    p = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      wait_cycles(BAUD);
    end
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] d, input logic stop,
                              input int unsigned p);
    if (stop) begin
      check({tag, " strobes"}, strobe_cyc.size(), 1);
      check({tag, " errs"}, err_cyc.size(), 0);
      if (strobe_cyc.size() > 0) begin
        check({tag, " strobe cycle"}, strobe_cyc[0], p + LAT);
        check({tag, " strobe data"}, strobe_dat[0], d);
      end
      last_good = d;
    end else begin
      check({tag, " strobes"}, strobe_cyc.size(), 0);
      check({tag, " errs"}, err_cyc.size(), 1);
      if (err_cyc.size() > 0) check({tag, " err cycle"}, err_cyc[0], p + LAT);
    end
    check({tag, " rx_data held"}, bus.rx_data, last_good);
    clear_queues();
  endtask

  initial begin
    int unsigned p;
    logic [7:0]  d;
    logic        stop;

    // Reset values
    wait_cycles(3);
    check("reset rx_data", bus.rx_data, 8'h00);
    check("reset new_rx_data", bus.new_rx_data, 1'b0);
    check("reset frame_err", bus.frame_err, 1'b0);
    check("reset busy", bus.busy, 1'b0);
    rstn = 1'b1;
    wait_cycles(5);

    send_frame(8'h73, 1'b1, p);
    expect_frame("byte 73", 8'h73, 1'b1, p);
    wait_cycles(10);

    // Back-to-back with no idle between frames
    send_frame(8'h65, 1'b1, p);
    expect_frame("b2b 65", 8'h65, 1'b1, p);
    send_frame(8'h00, 1'b1, p);
    expect_frame("b2b 00", 8'h00, 1'b1, p);
    wait_cycles(10);

    // Three-cycle glitch must be rejected at the start-bit sample
    rx = 1'b0;
    wait_cycles(3);
    rx = 1'b1;
    check("glitch busy high", bus.busy, 1'b1);
    wait_cycles(4);
    check("glitch busy dropped", bus.busy, 1'b0);
    wait_cycles(LAT + 10);
    check("glitch strobes", strobe_cyc.size(), 0);
    check("glitch errs", err_cyc.size(), 0);
    clear_queues();

    // Bad stop bit; line low one more bit before returning high
    send_frame(8'hA5, 1'b0, p);
    expect_frame("bad stop A5", 8'hA5, 1'b0, p);
    check("break busy", bus.busy, 1'b1);
    wait_cycles(BAUD);
    rx = 1'b1;
    wait_cycles(5);
    check("break released busy", bus.busy, 1'b0);
    send_frame(8'h31, 1'b1, p);
    expect_frame("after err 31", 8'h31, 1'b1, p);
    wait_cycles(10);

    // Line held low through reset release
    rstn = 1'b0;
    rx   = 1'b0;
    wait_cycles(3);
    rstn = 1'b1;
    clear_queues();
    last_good = 8'h00;
    p = cyc;
    wait_cycles(200);
    check("held low errs", err_cyc.size(), 1);
    if (err_cyc.size() > 0) check("held low err cycle", err_cyc[0], p + LAT);
    check("held low strobes", strobe_cyc.size(), 0);
    check("held low busy", bus.busy, 1'b1);
    check("held low rx_data", bus.rx_data, 8'h00);
    rx = 1'b1;
    wait_cycles(5);
    check("held low released busy", bus.busy, 1'b0);
    clear_queues();
    send_frame(8'h67, 1'b1, p);
    expect_frame("after break 67", 8'h67, 1'b1, p);
    wait_cycles(10);

    // Reset in the middle of data bit 4 of 0xFF
    rx = 1'b0;
    wait_cycles(BAUD);
    rx = 1'b1;
    wait_cycles(4 * BAUD + BAUD / 2);
    rstn = 1'b0;
    #1;
    check("midreset rx_data", bus.rx_data, 8'h00);
    check("midreset new_rx_data", bus.new_rx_data, 1'b0);
    check("midreset frame_err", bus.frame_err, 1'b0);
    check("midreset busy", bus.busy, 1'b0);
    wait_cycles(2);
    rstn = 1'b1;
    wait_cycles(6 * BAUD);
    check("midreset strobes", strobe_cyc.size(), 0);
    check("midreset errs", err_cyc.size(), 0);
    clear_queues();
    last_good = 8'h00;
    send_frame(8'h0F, 1'b1, p);
    expect_frame("after reset 0F", 8'h0F, 1'b1, p);
    wait_cycles(10);

    // Randomized frames with random stop validity and gaps (including zero)
    for (int i = 0; i < 12; i++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      send_frame(d, stop, p);
      expect_frame($sformatf("rand %0d", i), d, stop, p);
      if (!stop) begin
        wait_cycles(BAUD);
        rx = 1'b1;
        wait_cycles(BAUD);
      end else begin
        wait_cycles($urandom_range(0, 2) * 3);
      end
    end
    wait_cycles(BAUD);

    check("strobe/err overlap", overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
